// File: rtl/comparador_pkg.sv
// Shared types, constants and golden compare function for the 2-bit comparator self-test.
package comparador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam int NUM_CODES = 16;
    localparam int CODE_W    = 4;
    localparam int RES_W     = 3;
    localparam int ERR_W     = 5;
    localparam int HOLD_W    = 8;

    // Code layout is {A,B,C,D}: X = code[3:2], Y = code[1:0]; result is {X>Y, X==Y, X<Y}.
    function automatic logic [RES_W-1:0] golden_cmp(input logic [CODE_W-1:0] code);
        logic [1:0] x;
        logic [1:0] y;
        x = code[3:2];
        y = code[1:0];
        golden_cmp = {(x > y), (x == y), (x < y)};
    endfunction

endpackage

// File: rtl/modelo_comparador.sv
// Combinational golden reference for the 2-bit magnitude comparator.
module modelo_comparador
    import comparador_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    output logic [RES_W-1:0]  o_expected
);

    assign o_expected = golden_cmp(i_code);

endmodule

// File: rtl/secuenciador_comparador.sv
// Self-test sequencer: sweeps all 16 comparator codes and checks F1/F2/F3 against a golden model.
// Optional SECUENCIADOR_FAILMAP_EN adds a 16-bit per-code failure map output.
module secuenciador_comparador
    import comparador_pkg::*;
#(
    parameter int HOLD_CYCLES = 10
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              A,
    output logic              B,
    output logic              C,
    output logic              D,
    input  logic              F1,
    input  logic              F2,
    input  logic              F3,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [CODE_W-1:0] fail_code
`ifdef SECUENCIADOR_FAILMAP_EN
    ,
    output logic [NUM_CODES-1:0] fail_map
`endif
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CODE_W-1:0] CODE_LAST = CODE_W'(NUM_CODES - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [CODE_W-1:0]   r_code;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [ERR_W-1:0]    r_err_count;
    logic [CODE_W-1:0]   r_fail_code;
    logic                r_pass;

    logic [RES_W-1:0]    w_expected;
    logic [RES_W-1:0]    w_observed;
    logic                w_start_accept;
    logic                w_sample;
    logic                w_mismatch;
    logic                w_last_code;
    logic [ERR_W-1:0]    w_err_next;
    logic [CODE_W-1:0]   w_drive;

    modelo_comparador u_modelo (
        .i_code     (r_code),
        .o_expected (w_expected)
    );

    assign w_observed     = {F1, F2, F3};
    assign w_start_accept = (r_state == IDLE) && start;
    assign w_sample       = (r_state == DRIVE) && (r_hold_cnt == HOLD_LAST);
    // Golden results are always one-hot, so any non-one-hot response also fails this test.
    assign w_mismatch     = w_sample && (w_observed != w_expected);
    assign w_last_code    = (r_code == CODE_LAST);
    assign w_err_next     = r_err_count + ERR_W'(w_mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_drive      = '0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = DRIVE;
                end
            end
            DRIVE: begin
                w_drive = r_code;
                busy    = 1'b1;
                if (w_sample && w_last_code) begin
                    w_next_state = FIN;
                end
            end
            FIN: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign {A, B, C, D} = w_drive;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code      <= '0;
            r_hold_cnt  <= '0;
            r_err_count <= '0;
            r_fail_code <= '0;
            r_pass      <= 1'b0;
        end else if (w_start_accept) begin
            r_code      <= '0;
            r_hold_cnt  <= '0;
            r_err_count <= '0;
            r_fail_code <= '0;
            r_pass      <= 1'b0;
        end else if (r_state == DRIVE) begin
            if (w_sample) begin
                r_hold_cnt <= '0;
                if (!w_last_code) begin
                    r_code <= r_code + CODE_W'(1);
                end
                if (w_mismatch) begin
                    r_err_count <= w_err_next;
                    if (r_err_count == '0) begin
                        r_fail_code <= r_code;
                    end
                end
                // Verdict is latched on the final sample so it is valid during the done cycle.
                if (w_last_code) begin
                    r_pass <= (w_err_next == '0);
                end
            end else begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
        end
    end

    assign err_count = r_err_count;
    assign fail_code = r_fail_code;
    assign pass      = r_pass;

`ifdef SECUENCIADOR_FAILMAP_EN
    logic [NUM_CODES-1:0] r_fail_map;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_map <= '0;
        end else if (w_start_accept) begin
            r_fail_map <= '0;
        end else if (w_mismatch) begin
            r_fail_map[r_code] <= 1'b1;
        end
    end

    assign fail_map = r_fail_map;
`endif

endmodule

// File: tb/tb_secuenciador_comparador.sv
// Scoreboard bench for secuenciador_comparador: two instances (HOLD_CYCLES=10 and 1) with a fault-injectable comparator.
module tb_secuenciador_comparador;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    logic A0, B0, C0, D0, F10, F20, F30, busy0, done0, pass0;
    logic [4:0] err0;
    logic [3:0] fc0;
    logic A1, B1, C1, D1, F11, F21, F31, busy1, done1, pass1;
    logic [4:0] err1;
    logic [3:0] fc1;
`ifdef SECUENCIADOR_FAILMAP_EN
    logic [15:0] map0, map1;
`endif

    int faultMode = 0;
    int cyc = 0;
    int totalChecks = 0;
    int badChecks = 0;

    typedef struct {
        int         doneCyc;
        logic [4:0] err;
        logic [3:0] fc;
        logic       passExp;
        logic [15:0] map;
    } result_t;

    result_t q0[$];
    result_t q1[$];
    result_t got0, got1, last0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Comparator under test: mode 0 correct, 1 F2 stuck at 0, 2 F1/F3 swapped.
    function automatic logic [2:0] cmpModel(input logic [3:0] code, input int mode);
        logic [1:0] x;
        logic [1:0] y;
        logic [2:0] g;
        x = code[3:2];
        y = code[1:0];
        g = {(x > y), (x == y), (x < y)};
        if (mode == 1) g[1] = 1'b0;
        else if (mode == 2) g = {g[0], g[1], g[2]};
        return g;
    endfunction

    function automatic result_t predict(input int mode, input int t, input int hold);
        result_t r;
        r.doneCyc = t + 16 * hold;
        r.err = '0;
        r.fc = '0;
        r.map = '0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] c;
            c = 4'(i);
            if (cmpModel(c, mode) != cmpModel(c, 0)) begin
                if (r.err == 5'd0) r.fc = c;
                r.err = r.err + 5'd1;
                r.map[i] = 1'b1;
            end
        end
        r.passExp = (r.err == 5'd0);
        return r;
    endfunction

    assign {F10, F20, F30} = cmpModel({A0, B0, C0, D0}, faultMode);
    assign {F11, F21, F31} = cmpModel({A1, B1, C1, D1}, 0);

    secuenciador_comparador #(.HOLD_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .A(A0), .B(B0), .C(C0), .D(D0),
        .F1(F10), .F2(F20), .F3(F30),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_code(fc0)
`ifdef SECUENCIADOR_FAILMAP_EN
        , .fail_map(map0)
`endif
    );

    secuenciador_comparador #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .A(A1), .B(B1), .C(C1), .D(D1),
        .F1(F11), .F2(F21), .F3(F31),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_code(fc1)
`ifdef SECUENCIADOR_FAILMAP_EN
        , .fail_map(map1)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int which, input int mode);
        @(negedge clk);
        if (which == 0) begin
            faultMode = mode;
            q0.push_back(predict(mode, cyc + 1, 10));
            start0 = 1'b1;
        end else begin
            q1.push_back(predict(0, cyc + 1, 1));
            start1 = 1'b1;
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic waitDrain(input int which);
        int n;
        n = 0;
        while (((which == 0) ? q0.size() : q1.size()) != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", (which == 0) ? q0.size() : q1.size(), 0);
    endtask

    task automatic waitCode(input logic [3:0] c);
        int n;
        n = 0;
        while ({A0, B0, C0, D0} != c && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_code", {A0, B0, C0, D0}, c);
    endtask

    // Monitor for the HOLD_CYCLES=10 instance: code order, dwell and end-of-sweep scoreboard.
    logic prevBusy0 = 1'b0;
    logic [3:0] prevCode0 = '0;
    logic [3:0] curCode0;
    int dwell0 = 0;
    int expCode0 = 0;

    always @(negedge clk) begin
        curCode0 = {A0, B0, C0, D0};
        if (busy0) begin
            if (!prevBusy0) begin
                checkOutput("first_code", curCode0, 0);
                expCode0 = 1;
                dwell0 = 1;
            end else if (curCode0 == prevCode0) begin
                dwell0++;
            end else begin
                checkOutput("dwell", dwell0, 10);
                checkOutput("code_order", curCode0, expCode0);
                expCode0++;
                dwell0 = 1;
            end
        end
        if (done0) begin
            checkOutput("last_dwell", dwell0, 10);
            checkOutput("fin_drive", curCode0, 0);
            checkOutput("fin_busy", busy0, 0);
            if (q0.size() == 0) begin
                checkOutput("spurious_done0", done0, 0);
            end else begin
                got0 = q0.pop_front();
                checkOutput("done_cycle0", cyc, got0.doneCyc);
                checkOutput("err_count0", err0, got0.err);
                checkOutput("pass0", pass0, got0.passExp);
                if (got0.err != 5'd0) checkOutput("fail_code0", fc0, got0.fc);
`ifdef SECUENCIADOR_FAILMAP_EN
                checkOutput("fail_map0", map0, got0.map);
`endif
                last0 = got0;
            end
        end
        prevBusy0 = busy0;
        prevCode0 = curCode0;
    end

    always @(negedge clk) begin
        if (done1) begin
            checkOutput("fin_drive1", {A1, B1, C1, D1}, 0);
            if (q1.size() == 0) begin
                checkOutput("spurious_done1", done1, 0);
            end else begin
                got1 = q1.pop_front();
                checkOutput("done_cycle1", cyc, got1.doneCyc);
                checkOutput("err_count1", err1, got1.err);
                checkOutput("pass1", pass1, got1.passExp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got=running expected=finished");
        badChecks++;
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int n;

        repeat (2) @(negedge clk);
        checkOutput("rst_drive", {A0, B0, C0, D0}, 0);
        checkOutput("rst_busy", busy0, 0);
        checkOutput("rst_done", done0, 0);
        checkOutput("rst_pass", pass0, 0);
        checkOutput("rst_err", err0, 0);
        checkOutput("rst_fc", fc0, 0);
        checkOutput("rst_busy1", busy1, 0);
`ifdef SECUENCIADOR_FAILMAP_EN
        checkOutput("rst_map", map0, 0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean sweep, then verdict held in IDLE.
        applyStimulus(0, 0);
        waitDrain(0);
        repeat (3) @(negedge clk);
        checkOutput("hold_pass", pass0, last0.passExp);
        checkOutput("hold_err", err0, last0.err);

        // F2 stuck at 0, then F1/F3 swapped.
        applyStimulus(0, 1);
        waitDrain(0);
        repeat (3) @(negedge clk);
        checkOutput("hold_fc", fc0, last0.fc);
        applyStimulus(0, 2);
        waitDrain(0);

        // Start re-asserted mid-sweep is ignored.
        applyStimulus(0, 0);
        waitCode(4'd7);
        start0 = 1'b1;
        repeat (3) @(negedge clk);
        start0 = 1'b0;
        waitDrain(0);
        repeat (200) @(negedge clk);
        checkOutput("no_requeue", busy0, 0);

        // Reset mid-sweep aborts immediately, then a fresh clean sweep.
        applyStimulus(0, 1);
        waitCode(4'd9);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_drive", {A0, B0, C0, D0}, 0);
        checkOutput("abort_busy", busy0, 0);
        checkOutput("abort_done", done0, 0);
        checkOutput("abort_err", err0, 0);
        q0.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        applyStimulus(0, 0);
        waitDrain(0);

        // HOLD_CYCLES=1 single sweep.
        applyStimulus(1, 0);
        waitDrain(1);

        // Back-to-back: start held through FIN is accepted after one IDLE cycle.
        @(negedge clk);
        t = cyc + 1;
        q1.push_back(predict(0, t, 1));
        q1.push_back(predict(0, t + 18, 1));
        start1 = 1'b1;
        n = 0;
        while (cyc < t + 18 && n < 100) begin
            @(negedge clk);
            n++;
        end
        start1 = 1'b0;
        waitDrain(1);
        repeat (5) @(negedge clk);
        checkOutput("b2b_idle", busy1, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
